i2c_temp_target: RTL

I2C target (responder) that emulates the board's 7-bit temperature sensor at address 0x18, for simulation and loop-back bring-up of the byte-level I2C master and its controller FSM. It samples the open-drain SCL/SDA bus, decodes START/STOP/address/pointer/data, and answers reads of the configuration, temperature and ID registers. The configuration register is writable, and the temperature value is supplied on a port. It sits on the bus opposite the master, driving SDA only through an open-drain enable.

---
 rtl/i2c_temp_target_pkg.sv | 25 ++
 rtl/i2c_temp_target_if.sv | 10 +
 rtl/i2c_temp_target_line_sync.sv | 45 ++++
 rtl/i2c_temp_target.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_temp_target_pkg.sv
// Shared I2C definitions: target FSM states, register pointers and the
// temperature sensor bus address.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WACK,
    ST_RDATA,
    ST_RACK,
    ST_IGNORE
  } i2c_state_e;

  localparam logic [7:0] PTR_CONFIG = 8'd1;
  localparam logic [7:0] PTR_TEMP   = 8'd5;
  localparam logic [7:0] PTR_MFG    = 8'd6;
  localparam logic [7:0] PTR_DEV    = 8'd7;

  localparam logic [6:0] I2C_ADDR_TEMP = 7'b0011000;

endpackage

// File: rtl/i2c_temp_target_if.sv
// Open-drain I2C pin bundle: SCL and the resolved SDA level come in, and the
// SDA pull-down enable goes out.
interface i2c_temp_target_if;
  logic scl;
  logic sda_in;
  logic sda_oe;

  modport master (output scl, output sda_in, input sda_oe);
  modport slave  (input scl, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_temp_target_line_sync.sv
// Two-flop synchronizers on SCL/SDA followed by registered edge, START and
// STOP detection (3 clk from pin to pulse).
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic sda_o
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_prev_q;
  logic       sda_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      scl_rise_o <= 1'b0;
      scl_fall_o <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      sda_o      <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
      scl_rise_o <= scl_sync_q[1] & ~scl_prev_q;
      scl_fall_o <= ~scl_sync_q[1] & scl_prev_q;
      // SDA edges only count as START/STOP while SCL stays high across them
      start_o    <= scl_sync_q[1] & scl_prev_q & sda_prev_q & ~sda_sync_q[1];
      stop_o     <= scl_sync_q[1] & scl_prev_q & ~sda_prev_q & sda_sync_q[1];
      sda_o      <= sda_sync_q[1];
    end
  end

endmodule

// File: rtl/i2c_temp_target.sv
// I2C temperature-sensor target: decodes address/pointer/data and serves the
// configuration, temperature and ID registers over an open-drain SDA.
module i2c_temp_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR   = I2C_ADDR_TEMP,
  parameter logic [15:0] CONF_RESET = 16'h0000,
  parameter logic [15:0] MFG_ID     = 16'h0054,
  parameter logic [15:0] DEV_ID     = 16'h0400
) (
  input  logic                     clk,
  input  logic                     rst_n,
  i2c_temp_target_if.slave         bus,
  input  logic [15:0]              temp_in,
  output logic [15:0]              config_out,
  output logic                     cfg_wr,
  output logic                     busy
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_line_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (bus.scl),
    .sda_i      (bus.sda_in),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det),
    .sda_o      (sda_s)
  );

  i2c_state_e  state_q;
  logic [3:0]  bitcnt_q;
  logic [7:0]  shift_q;
  logic [7:0]  ptr_q;
  logic [7:0]  hold_q;
  logic [1:0]  wcnt_q;
  logic [15:0] shadow_q;
  logic        byte_idx_q;
  logic        ack_on_q;
  logic        got_ack_q;
  logic        rw_q;
  logic        sda_oe_q;
  logic [15:0] config_q;
  logic        cfg_wr_q;
  logic        busy_q;

  logic [7:0]  rx_byte;
  logic [7:0]  tx_byte;
  logic [7:0]  nxt_byte;
  logic [15:0] reg_rd;

  always_comb begin
    rx_byte  = {shift_q[6:0], sda_s};
    tx_byte  = byte_idx_q ? shadow_q[7:0]  : shadow_q[15:8];
    nxt_byte = byte_idx_q ? shadow_q[15:8] : shadow_q[7:0];
    reg_rd   = '0;
    case (ptr_q)
      PTR_CONFIG: reg_rd = config_q;
      PTR_TEMP:   reg_rd = temp_in;
      PTR_MFG:    reg_rd = MFG_ID;
      PTR_DEV:    reg_rd = DEV_ID;
      default:    reg_rd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      hold_q     <= '0;
      wcnt_q     <= '0;
      shadow_q   <= '0;
      byte_idx_q <= 1'b0;
      ack_on_q   <= 1'b0;
      got_ack_q  <= 1'b0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      config_q   <= CONF_RESET;
      cfg_wr_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      cfg_wr_q <= 1'b0;
      if (stop_det) begin
        state_q  <= ST_IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (start_det) begin
        state_q  <= ST_ADDR;
        bitcnt_q <= '0;
        sda_oe_q <= 1'b0;
      end else begin
        case (state_q)
          ST_ADDR: if (scl_rise) begin
            shift_q <= rx_byte;
            if (bitcnt_q == 4'd7) begin
              bitcnt_q <= '0;
              ack_on_q <= 1'b0;
              if (rx_byte[7:1] == DEV_ADDR) begin
                rw_q    <= rx_byte[0];
                busy_q  <= 1'b1;
                state_q <= ST_ADDR_ACK;
              end else begin
                busy_q  <= 1'b0;
                state_q <= ST_IGNORE;
              end
            end else begin
              bitcnt_q <= bitcnt_q + 4'd1;
            end
          end
          // First fall ends the 8th bit (pull SDA), second fall ends the ACK.
          ST_ADDR_ACK: if (scl_fall) begin
            if (!ack_on_q) begin
              sda_oe_q <= 1'b1;
              ack_on_q <= 1'b1;
            end else if (rw_q) begin
              shadow_q   <= reg_rd;
              byte_idx_q <= 1'b0;
              bitcnt_q   <= '0;
              sda_oe_q   <= ~reg_rd[15];
              state_q    <= ST_RDATA;
            end else begin
              sda_oe_q <= 1'b0;
              bitcnt_q <= '0;
              state_q  <= ST_PTR;
            end
          end
          ST_PTR: if (scl_rise) begin
            shift_q <= rx_byte;
            if (bitcnt_q == 4'd7) begin
              ptr_q    <= rx_byte;
              ack_on_q <= 1'b0;
              state_q  <= ST_PTR_ACK;
            end else begin
              bitcnt_q <= bitcnt_q + 4'd1;
            end
          end
          ST_PTR_ACK, ST_WACK: if (scl_fall) begin
            if (!ack_on_q) begin
              sda_oe_q <= 1'b1;
              ack_on_q <= 1'b1;
            end else begin
              sda_oe_q <= 1'b0;
              bitcnt_q <= '0;
              if (state_q == ST_PTR_ACK) wcnt_q <= '0;
              state_q  <= ST_WDATA;
            end
          end
          ST_WDATA: if (scl_rise) begin
            shift_q <= rx_byte;
            if (bitcnt_q == 4'd7) begin
              if (wcnt_q == 2'd0) begin
                hold_q <= rx_byte;
              end else if (wcnt_q == 2'd1 && ptr_q == PTR_CONFIG) begin
                config_q <= {hold_q, rx_byte};
                cfg_wr_q <= 1'b1;
              end
              if (wcnt_q != 2'd2) wcnt_q <= wcnt_q + 2'd1;
              ack_on_q <= 1'b0;
              state_q  <= ST_WACK;
            end else begin
              bitcnt_q <= bitcnt_q + 4'd1;
            end
          end
          // Bit 7 is already on the bus on entry; each fall presents the next.
          ST_RDATA: begin
            if (scl_rise) begin
              bitcnt_q <= bitcnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bitcnt_q == 4'd8) begin
                sda_oe_q  <= 1'b0;
                got_ack_q <= 1'b0;
                state_q   <= ST_RACK;
              end else begin
                sda_oe_q <= ~tx_byte[3'd7 - bitcnt_q[2:0]];
              end
            end
          end
          ST_RACK: begin
            if (scl_rise) begin
              if (!sda_s) got_ack_q <= 1'b1;
              else        state_q   <= ST_IGNORE;
            end else if (scl_fall && got_ack_q) begin
              byte_idx_q <= ~byte_idx_q;
              bitcnt_q   <= '0;
              sda_oe_q   <= ~nxt_byte[7];
              state_q    <= ST_RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.sda_oe = sda_oe_q;
  assign config_out = config_q;
  assign cfg_wr     = cfg_wr_q;
  assign busy       = busy_q;

endmodule
